sysid_check_master: RTL

- Avalon-MM master that reads the 2-word system-ID slave (word 0 = system ID, word 1 = build timestamp) and compares both words against the values expected at build time.
- Sits next to the Nios II data master on the system interconnect. Drives a hardware "system image matches software build" status flag that is sampled by boot logic and LEDs.
- Handles waitrequest stalls and variable read latency (readdatavalid), and times out if the slave never responds.

---
 rtl/sysid_check_pkg.sv | 27 ++
 rtl/sysid_check_master_timer.sv | 31 +++
 rtl/sysid_check_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sysid_check_pkg.sv
// Shared definitions for the system-ID check master.
//   state_e    : FSM state encoding (3 bits)
//   WORD_*_OFS : byte offsets of the two sysid slave words
//   cnt_width  : timeout counter width, clog2(limit+1)
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_ID = 3'd1,
    ST_RSP_ID = 3'd2,
    ST_REQ_TS = 3'd3,
    ST_RSP_TS = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  localparam int unsigned WORD_ID_OFS = 0;
  localparam int unsigned WORD_TS_OFS = 4;

  // Smallest w with 2**w > limit, i.e. enough bits to hold 0..limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = 1;
    while (w < 32 && (32'd1 << w) <= limit) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/sysid_check_master_timer.sv
// Per-access timeout counter.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : restart the count at zero (priority over en)
//   en           : count this cycle
//   expired      : current cycle is the last one allowed (count == LIMIT-1)
module avm_read_timer #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so a stuck enable can never wrap back to zero.
  always_ff @(posedge clock) begin
    if (reset || clear)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + CNT_W'(1);
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the two sysid words (ID, timestamp)
// and compares them to build-time constants.
//   clock, reset        : system clock, synchronous active-high reset
//   start               : one-cycle pulse, begins a check from IDLE
//   avm_*               : Avalon-MM read master (address, read, waitrequest,
//                         readdata, readdatavalid)
//   busy                : check in progress
//   done                : one-cycle completion pulse
//   pass                : sticky, both words matched
//   timeout_err         : sticky, last check aborted on timeout
//   id_value, ts_value  : last captured words
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]       EXPECTED_ID    = 32'd7,
  parameter logic [31:0]       EXPECTED_TS    = 32'd1383840915,
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam int unsigned       CNT_W   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_ID = BASE_ADDR + ADDR_W'(WORD_ID_OFS);
  localparam logic [ADDR_W-1:0] ADDR_TS = BASE_ADDR + ADDR_W'(WORD_TS_OFS);

  state_e state;
  logic   match_id, match_ts;
  logic   tmr_clear, tmr_en, tmr_expired;

  // The count restarts for each request: held at zero in IDLE and cleared
  // when word 0 arrives, so both accesses get the full budget.
  always_comb begin
    tmr_clear = (state == ST_IDLE) || (state == ST_RSP_ID && avm_readdatavalid);
    tmr_en    = (state == ST_REQ_ID) || (state == ST_RSP_ID) ||
                (state == ST_REQ_TS) || (state == ST_RSP_TS);
  end

  avm_read_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      avm_address <= BASE_ADDR;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      match_id    <= 1'b0;
      match_ts    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // done is high only in the first IDLE cycle; a start that lands
          // together with it is dropped, not deferred.
          if (start && !done) begin
            state       <= ST_REQ_ID;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
            busy        <= 1'b1;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            match_id    <= 1'b0;
            match_ts    <= 1'b0;
          end
        end

        ST_REQ_ID, ST_REQ_TS: begin
          // Address and read stay put while the slave stalls.
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= (state == ST_REQ_ID) ? ST_RSP_ID : ST_RSP_TS;
          end else if (tmr_expired) begin
            avm_read    <= 1'b0;
            timeout_err <= 1'b1;
            pass        <= 1'b0;
            state       <= ST_FINISH;
          end
        end

        ST_RSP_ID: begin
          // A response in the final allowed cycle still counts.
          if (avm_readdatavalid) begin
            id_value    <= avm_readdata;
            match_id    <= (avm_readdata == EXPECTED_ID);
            avm_read    <= 1'b1;
            avm_address <= ADDR_TS;
            state       <= ST_REQ_TS;
          end else if (tmr_expired) begin
            timeout_err <= 1'b1;
            pass        <= 1'b0;
            state       <= ST_FINISH;
          end
        end

        ST_RSP_TS: begin
          if (avm_readdatavalid) begin
            ts_value <= avm_readdata;
            match_ts <= (avm_readdata == EXPECTED_TS);
            state    <= ST_FINISH;
          end else if (tmr_expired) begin
            timeout_err <= 1'b1;
            pass        <= 1'b0;
            state       <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= match_id && match_ts && !timeout_err;
          state <= ST_IDLE;
        end

        default: begin
          avm_read <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
